// File: rtl/ste_chain_matcher_if.sv
// Stream, configuration and report signals of the STE chain matcher.
interface ste_chain_matcher_if #(
  parameter int unsigned BEAT_W   = 16,
  parameter int unsigned OFFSET_W = 32,
  parameter int unsigned ADDR_W   = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [BEAT_W-1:0]   in_data;
  logic                in_sop;
  logic                cfg_we;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [BEAT_W-1:0]   cfg_value;
  logic [BEAT_W-1:0]   cfg_mask;
  logic                cfg_self;
  logic                rpt_valid;
  logic                rpt_ready;
  logic [OFFSET_W-1:0] rpt_offset;

  modport master (
    output in_valid, in_data, in_sop,
    output cfg_we, cfg_addr, cfg_value, cfg_mask, cfg_self,
    output rpt_ready,
    input  in_ready, rpt_valid, rpt_offset
  );

  modport slave (
    input  in_valid, in_data, in_sop,
    input  cfg_we, cfg_addr, cfg_value, cfg_mask, cfg_self,
    input  rpt_ready,
    output in_ready, rpt_valid, rpt_offset
  );
endinterface

// File: rtl/ste_chain_matcher.sv
// Linear chain of programmable state-transition elements with a one-deep
// report buffer carrying the offset of the beat that fired the last STE.
module ste_chain_matcher #(
  parameter int unsigned SYMBOL_W   = 8,
  parameter int unsigned SYMBOLS    = 2,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned START_MODE = 0,
  parameter int unsigned OFFSET_W   = 32
) (
  input logic               clock,
  input logic               reset_n,
  ste_chain_matcher_if.slave bus
);

  localparam int unsigned BEAT_W = SYMBOLS * SYMBOL_W;

  // Per-STE configuration; STE0 has no predecessor so it keeps no self-loop bit.
  logic [BEAT_W-1:0]   r_value [DEPTH];
  logic [BEAT_W-1:0]   r_mask  [DEPTH];
  logic [DEPTH-1:1]    r_self;

  // Chain state and report buffer.
  logic [DEPTH-1:1]    r_act;
  logic [OFFSET_W-1:0] r_off_cnt;
  logic                r_rpt_valid;
  logic [OFFSET_W-1:0] r_rpt_offset;

  logic                w_in_ready;
  logic                w_acc;
  logic                w_cfg_hit;
  logic [OFFSET_W-1:0] w_beat_off;
  logic [DEPTH-1:0]    w_cmp;
  logic [DEPTH-1:0]    w_en;
  logic [DEPTH-1:0]    w_match;

  // Handshake, beat offset and per-STE compare/enable.
  always_comb begin
    w_cmp      = '0;
    w_en       = '0;
    w_in_ready = !r_rpt_valid || bus.rpt_ready;
    w_acc      = bus.in_valid && w_in_ready;
    w_cfg_hit  = bus.cfg_we && (32'(bus.cfg_addr) < DEPTH);
    w_beat_off = bus.in_sop ? '0 : r_off_cnt;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_cmp[i] = ((bus.in_data ^ r_value[i]) & r_mask[i]) == '0;
    end
    w_en[0] = (START_MODE != 0) ? bus.in_sop : 1'b1;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_en[i] = r_act[i] && !bus.in_sop;
    end
    w_match = w_en & w_cmp;
  end

  // Run-time configuration; out-of-range addresses are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_value[i] <= '0;
        r_mask[i]  <= '1;
      end
      r_self <= '0;
    end else if (w_cfg_hit) begin
      r_value[bus.cfg_addr] <= bus.cfg_value;
      r_mask[bus.cfg_addr]  <= bus.cfg_mask;
      if (bus.cfg_addr != '0) begin
        r_self[bus.cfg_addr] <= bus.cfg_self;
      end
    end
  end

  // Activation propagation and offset counting on accepted beats only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_act     <= '0;
      r_off_cnt <= '0;
    end else if (w_acc) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_act[i] <= w_match[i-1] || (r_self[i] && w_match[i]);
      end
      r_off_cnt <= w_beat_off + OFFSET_W'(1);
    end
  end

  // Report buffer: a new hit refills it even while the old entry is popped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rpt_valid  <= 1'b0;
      r_rpt_offset <= '0;
    end else if (w_acc && w_match[DEPTH-1]) begin
      r_rpt_valid  <= 1'b1;
      r_rpt_offset <= w_beat_off;
    end else if (bus.rpt_ready) begin
      r_rpt_valid  <= 1'b0;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.rpt_valid  = r_rpt_valid;
  assign bus.rpt_offset = r_rpt_offset;

endmodule

// File: tb/tb_ste_chain_matcher.sv
// Scoreboard bench: u0 is an all-input build with a 4-bit offset counter,
// u1 a start-of-data build with a 32-bit counter.
module tb_ste_chain_matcher;

  logic clock;
  logic reset_n;

  ste_chain_matcher_if #(.BEAT_W(16), .OFFSET_W(4),  .ADDR_W(2)) if0 ();
  ste_chain_matcher_if #(.BEAT_W(16), .OFFSET_W(32), .ADDR_W(2)) if1 ();

  ste_chain_matcher #(.SYMBOL_W(8), .SYMBOLS(2), .DEPTH(3), .START_MODE(0), .OFFSET_W(4)) u0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if0)
  );

  ste_chain_matcher #(.SYMBOL_W(8), .SYMBOLS(2), .DEPTH(3), .START_MODE(1), .OFFSET_W(32)) u1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (if1)
  );

  int unsigned q0[$];
  int unsigned q1[$];
  int n_tot  = 0;
  int n_pass = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Report monitors: a report is consumed on every cycle valid and ready are both high.
  always @(negedge clock) begin
    if (reset_n && if0.rpt_valid && if0.rpt_ready) begin
      if (q0.size() == 0) begin
        n_tot++;
        $display("FAIL u0_unexpected_report: got offset %0d expected none", if0.rpt_offset);
      end else begin
        chk("u0_rpt_offset", 32'(if0.rpt_offset), q0.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && if1.rpt_valid && if1.rpt_ready) begin
      if (q1.size() == 0) begin
        n_tot++;
        $display("FAIL u1_unexpected_report: got offset %0d expected none", if1.rpt_offset);
      end else begin
        chk("u1_rpt_offset", if1.rpt_offset, q1.pop_front());
      end
    end
  end

  task automatic cfg(input int u, input int unsigned a, input logic [15:0] v,
                     input logic [15:0] m, input logic s);
    if (u == 0) begin
      if0.cfg_we = 1'b1; if0.cfg_addr = 2'(a); if0.cfg_value = v; if0.cfg_mask = m; if0.cfg_self = s;
    end else begin
      if1.cfg_we = 1'b1; if1.cfg_addr = 2'(a); if1.cfg_value = v; if1.cfg_mask = m; if1.cfg_self = s;
    end
    @(posedge clock); #1;
    if0.cfg_we = 1'b0;
    if1.cfg_we = 1'b0;
  endtask

  task automatic beat(input int u, input logic [15:0] d, input logic sop);
    int   wait_cycles;
    logic rdy;
    if (u == 0) begin
      if0.in_valid = 1'b1; if0.in_data = d; if0.in_sop = sop;
    end else begin
      if1.in_valid = 1'b1; if1.in_data = d; if1.in_sop = sop;
    end
    wait_cycles = 0;
    forever begin
      @(negedge clock);
      rdy = (u == 0) ? if0.in_ready : if1.in_ready;
      if (rdy) break;
      wait_cycles++;
      if (wait_cycles > 50) begin
        n_tot++;
        $display("FAIL beat_timeout: unit %0d in_ready stuck 0 for %0d cycles", u, wait_cycles);
        break;
      end
    end
    @(posedge clock); #1;
    if (u == 0) begin if0.in_valid = 1'b0; if0.in_sop = 1'b0; end
    else        begin if1.in_valid = 1'b0; if1.in_sop = 1'b0; end
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clock);
    chk({name, "_q0_empty"}, q0.size(), 0);
    chk({name, "_q1_empty"}, q1.size(), 0);
    @(posedge clock); #1;
  endtask

  task automatic std_cfg(input int u);
    cfg(u, 0, 16'h4141, 16'hFFFF, 1'b0);
    cfg(u, 1, 16'h4343, 16'hFFFF, 1'b1);
    cfg(u, 2, 16'h4300, 16'hFF00, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.in_sop = 1'b0; if0.rpt_ready = 1'b1;
    if0.cfg_we = 1'b0; if0.cfg_addr = '0; if0.cfg_value = '0; if0.cfg_mask = '0; if0.cfg_self = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_sop = 1'b0; if1.rpt_ready = 1'b1;
    if1.cfg_we = 1'b0; if1.cfg_addr = '0; if1.cfg_value = '0; if1.cfg_mask = '0; if1.cfg_self = 1'b0;
    repeat (2) @(posedge clock); #1;
    reset_n = 1'b1;

    // Reset state.
    chk("u0_reset_rpt_valid", 32'(if0.rpt_valid), 0);
    chk("u0_reset_in_ready",  32'(if0.in_ready), 1);
    chk("u0_reset_rpt_offset", 32'(if0.rpt_offset), 0);
    chk("u1_reset_rpt_valid", 32'(if1.rpt_valid), 0);
    chk("u1_reset_in_ready",  32'(if1.in_ready), 1);
    chk("u1_reset_rpt_offset", if1.rpt_offset, 0);

    // Test 1: basic chain with self-loop; out-of-range config write must be ignored.
    std_cfg(0);
    cfg(0, 3, 16'h0000, 16'h0000, 1'b1);
    q0.push_back(2); q0.push_back(3);
    beat(0, 16'h4141, 1'b1);
    beat(0, 16'h4343, 1'b0);
    beat(0, 16'h4343, 1'b0);
    beat(0, 16'h4354, 1'b0);
    drain("t1");

    // Test 2: consumer stalls from beat 2; input must back-pressure, then resume.
    q0.push_back(2); q0.push_back(3);
    beat(0, 16'h4141, 1'b1);
    beat(0, 16'h4343, 1'b0);
    if0.rpt_ready = 1'b0;
    beat(0, 16'h4343, 1'b0);
    fork
      beat(0, 16'h4354, 1'b0);
      begin
        @(negedge clock);
        chk("t2_in_ready_stalled", 32'(if0.in_ready), 0);
        chk("t2_held_offset", 32'(if0.rpt_offset), 2);
        repeat (4) @(negedge clock);
        chk("t2_in_ready_still_stalled", 32'(if0.in_ready), 0);
        @(posedge clock); #1;
        if0.rpt_ready = 1'b1;
      end
    join
    drain("t2");

    // Test 3: start-of-data build only arms STE1 from a sop beat.
    std_cfg(1);
    q1.push_back(2); q1.push_back(3);
    beat(1, 16'h4141, 1'b0);
    beat(1, 16'h4343, 1'b0);
    beat(1, 16'h4343, 1'b0);
    beat(1, 16'h4354, 1'b0);
    beat(1, 16'h0000, 1'b0);
    beat(1, 16'h4141, 1'b1);
    beat(1, 16'h4343, 1'b0);
    beat(1, 16'h4343, 1'b0);
    beat(1, 16'h4354, 1'b0);
    beat(1, 16'h4141, 1'b0);
    beat(1, 16'h4343, 1'b0);
    beat(1, 16'h4343, 1'b0);
    drain("t3");

    // Test 4: sop mid-match discards the pending prefix and restarts the offset.
    q0.push_back(3);
    beat(0, 16'h4141, 1'b1);
    beat(0, 16'h4343, 1'b0);
    beat(0, 16'h4354, 1'b1);
    beat(0, 16'h4141, 1'b0);
    beat(0, 16'h4343, 1'b0);
    beat(0, 16'h4343, 1'b0);
    drain("t4");

    // Test 5: 20 beats on a 4-bit counter; reports from beat 2 onward wrap 15 -> 0.
    for (int k = 2; k < 20; k++) q0.push_back(k % 16);
    beat(0, 16'h4141, 1'b1);
    for (int k = 1; k < 20; k++) beat(0, 16'h4343, 1'b0);
    drain("t5");

    // Test 6: reset mid-pattern clears the buffer, chain state and configuration.
    beat(0, 16'h4141, 1'b1);
    beat(0, 16'h4343, 1'b0);
    if0.rpt_ready = 1'b0;
    beat(0, 16'h4343, 1'b0);
    chk("t6_pre_reset_valid", 32'(if0.rpt_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("t6_reset_rpt_valid", 32'(if0.rpt_valid), 0);
    chk("t6_reset_in_ready",  32'(if0.in_ready), 1);
    chk("t6_reset_rpt_offset", 32'(if0.rpt_offset), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    if0.rpt_ready = 1'b1;
    q0.push_back(4);
    beat(0, 16'h4343, 1'b0);
    beat(0, 16'h4354, 1'b0);
    beat(0, 16'h0000, 1'b0);
    beat(0, 16'h0000, 1'b0);
    beat(0, 16'h0000, 1'b0);
    drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_tot);
    $fatal(1);
  end

endmodule
